prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
Parametrised program sequencer that replaces the separate program counter and jump-target lookup of the 8-bit core. Adds a four-phase req/done run handshake, a loadable jump-target LUT, and a call/return stack with overflow and underflow trapping. A stall input holds fetch. Sits between the decoder (jump/halt controls in) and instruction ROM (prog_ctr out).

Parameters:
D, 12, program counter width; address space 2^D
LUT_W, 4, LUT index width; 2^LUT_W absolute-target entries of D bits
STACK_D, 4, return-stack depth (entries of D bits), >=1
START_ADDR, 0, PC value loaded on run start

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  run request, level; four-phase with done
stall  input  1  hold PC this cycle (memory wait)
halt  input  1  decoded halt instruction
jump_en  input  1  take control transfer this cycle
jump_mode  input  2  00 relative, 01 absolute LUT, 10 call LUT, 11 return
branch_off  input  D  signed two's-complement relative offset
lut_idx  input  LUT_W  LUT entry selector for modes 01/10
lut_we  input  1  LUT write enable
lut_waddr  input  LUT_W  LUT write address
lut_wdata  input  D  LUT write data
prog_ctr  output  D  current fetch address
instr_valid  output  1  instruction at prog_ctr executes this cycle
done  output  1  run complete
stack_err  output  1  run ended by stack overflow/underflow
sp  output  clog2(STACK_D+1)  stack occupancy

Behaviour:
- Reset (reset=0, async): state IDLE; prog_ctr=0, done=0, stack_err=0, sp=0, instr_valid=0, all LUT entries 0. Reset mid-run aborts immediately.
- States IDLE, RUN, DONE. instr_valid = (state==RUN) & ~stall, combinational.
- IDLE: req=1 -> RUN next edge, prog_ctr<=START_ADDR, sp<=0, stack_err<=0.
- RUN, in one clock edge, priority order:
  1. stall=1: hold everything (halt/jump ignored).
  2. halt=1: -> DONE, prog_ctr held; halt beats jump_en.
  3. jump_en=1:
     - 00: prog_ctr<=prog_ctr+branch_off, mod 2^D.
     - 01: prog_ctr<=LUT[lut_idx].
     - 10: when sp==STACK_D, overflow: stack_err<=1, -> DONE, no push. Else push prog_ctr+1, sp+1, prog_ctr<=LUT[lut_idx].
     - 11: when sp==0, underflow: stack_err<=1, -> DONE. Else prog_ctr<=top, sp-1.
  4. Otherwise: prog_ctr<=prog_ctr+1, wraps 2^D-1 -> 0.
- req deasserted during RUN is ignored; the run ends only via halt or a stack error.
- DONE: done=1 (registered, asserted the cycle after entering). Stay while req=1. When req=0, -> IDLE next edge, and done falls with that edge. prog_ctr and stack_err hold until the next run start.
- LUT write is accepted in any state. A same-cycle write and read of one index gives the old value to the jump. Write lands at the edge.
- Pushed return address is prog_ctr+1 mod 2^D.
- Stack entries are not cleared on pop or run start; only sp is reset.

Test Plan:
- Reset, then req=1, no jumps, halt at PC=5 -> prog_ctr 0,1,2,3,4,5; done=1 the cycle after halt; drop req -> done=0 and IDLE one edge later.
- D=12, PC=10, mode 00, branch_off=0xFFD (-3) -> PC=7. PC=0xFFF with no jump -> PC=0x000.
- Write LUT[3]=0x120. At PC=0x040, call idx 3 -> PC=0x120, sp=1. Return -> PC=0x041, sp=0.
- STACK_D=4: five nested calls -> the fifth sets stack_err=1, done=1, sp=4. Return with sp=0 on a fresh run -> stack_err=1.
- halt and jump_en both high -> DONE, PC unchanged. stall=1 for 3 cycles -> PC held, instr_valid=0.
- reset low mid-RUN at PC=0x033 with sp=2 -> prog_ctr=0, sp=0, done=0 immediately, without waiting for a clock. A LUT write plus call to the same index in one cycle -> jump uses the old entry.

Source files
------------

// File: rtl/prog_sequencer.sv
// Program sequencer: PC generation, jump-target LUT, call/return stack and a
// four-phase req/done run handshake between the decoder and instruction ROM.
module prog_sequencer #(
  parameter int D          = 12,
  parameter int LUT_W      = 4,
  parameter int STACK_D    = 4,
  parameter int START_ADDR = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req,
  input  logic                             stall,
  input  logic                             halt,
  input  logic                             jump_en,
  input  logic [1:0]                       jump_mode,
  input  logic [D-1:0]                     branch_off,
  input  logic [LUT_W-1:0]                 lut_idx,
  input  logic                             lut_we,
  input  logic [LUT_W-1:0]                 lut_waddr,
  input  logic [D-1:0]                     lut_wdata,
  output logic [D-1:0]                     prog_ctr,
  output logic                             instr_valid,
  output logic                             done,
  output logic                             stack_err,
  output logic [$clog2(STACK_D+1)-1:0]     sp
);

  localparam int SP_W     = $clog2(STACK_D + 1);
  localparam int IDX_W    = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam int LUT_N    = 2 ** LUT_W;
  localparam int STK_N    = 2 ** IDX_W;

  localparam logic [1:0] MODE_REL  = 2'b00;
  localparam logic [1:0] MODE_ABS  = 2'b01;
  localparam logic [1:0] MODE_CALL = 2'b10;
  localparam logic [1:0] MODE_RET  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [D-1:0]     lut_mem [LUT_N];
  logic [D-1:0]     stack_mem [STK_N];
  logic [D-1:0]     lut_rd;
  logic [D-1:0]     pc_inc;
  logic [D-1:0]     stack_top;
  logic [IDX_W-1:0] sp_dec;
  logic             stack_full;
  logic             stack_empty;
  logic             advance;
  logic             push_en;

  assign lut_rd      = lut_mem[lut_idx];
  assign pc_inc      = prog_ctr + 1'b1;
  assign sp_dec      = IDX_W'(sp - 1'b1);
  assign stack_top   = stack_mem[sp_dec];
  assign stack_full  = (sp == SP_W'(STACK_D));
  assign stack_empty = (sp == '0);
  assign instr_valid = (state_reg == RUN) & ~stall;

  // A control transfer is only considered on an unstalled, non-halting RUN cycle.
  assign advance = (state_reg == RUN) & ~stall & ~halt;
  assign push_en = advance & jump_en & (jump_mode == MODE_CALL) & ~stack_full;

  // LUT entries are individually reset; the jump reads the pre-edge value.
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lut_mem[gi] <= '0;
      end else if (lut_we && (lut_waddr == LUT_W'(gi))) begin
        lut_mem[gi] <= lut_wdata;
      end
    end
  end

  // Stack contents are never cleared; only sp tracks validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[sp[IDX_W-1:0]] <= pc_inc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      prog_ctr  <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req) begin
            state_reg <= RUN;
            prog_ctr  <= D'(START_ADDR);
            sp        <= '0;
            stack_err <= 1'b0;
          end
        end
        RUN: begin
          if (!stall) begin
            if (halt) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else if (jump_en) begin
              case (jump_mode)
                MODE_REL: prog_ctr <= prog_ctr + branch_off;
                MODE_ABS: prog_ctr <= lut_rd;
                MODE_CALL: begin
                  if (stack_full) begin
                    stack_err <= 1'b1;
                    state_reg <= DONE;
                    done      <= 1'b1;
                  end else begin
                    prog_ctr <= lut_rd;
                    sp       <= sp + 1'b1;
                  end
                end
                default: begin
                  if (stack_empty) begin
                    stack_err <= 1'b1;
                    state_reg <= DONE;
                    done      <= 1'b1;
                  end else begin
                    prog_ctr <= stack_top;
                    sp       <= sp - 1'b1;
                  end
                end
              endcase
            end else begin
              prog_ctr <= pc_inc;
            end
          end
        end
        DONE: begin
          if (!req) begin
            state_reg <= IDLE;
            done      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: handshake, jumps, LUT, stack traps, stall, async reset.
module tb_prog_sequencer;

  localparam int D = 12;
  localparam int LUT_W = 4;
  localparam int STACK_D = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req, stall, halt, jump_en, lut_we;
  logic [1:0]       jump_mode;
  logic [D-1:0]     branch_off, lut_wdata;
  logic [LUT_W-1:0] lut_idx, lut_waddr;
  logic [D-1:0]     prog_ctr;
  logic             instr_valid, done, stack_err;
  logic [2:0]       sp;

  int checks = 0;
  int failures = 0;

  prog_sequencer #(.D(D), .LUT_W(LUT_W), .STACK_D(STACK_D), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .halt(halt),
    .jump_en(jump_en), .jump_mode(jump_mode), .branch_off(branch_off),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .instr_valid(instr_valid), .done(done),
    .stack_err(stack_err), .sp(sp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctl();
    halt = 0; jump_en = 0; jump_mode = 2'b00; branch_off = '0;
    lut_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0; stall = 0;
  endtask

  initial begin
    reset = 0; req = 0;
    clr_ctl();
    #2;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_done", done, 0);
    chk("rst_sp", sp, 0);
    chk("rst_err", stack_err, 0);
    chk("rst_valid", instr_valid, 0);
    tick(); tick();
    reset = 1;
    tick();
    chk("idle_pc", prog_ctr, 0);

    // Linear run to PC=5, halt, handshake back to IDLE
    req = 1;
    tick();
    chk("run_pc0", prog_ctr, 0);
    chk("run_valid", instr_valid, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("run_pc%0d", i), prog_ctr, i);
    end
    halt = 1;
    tick();
    halt = 0;
    chk("halt_done", done, 1);
    chk("halt_pc", prog_ctr, 5);
    chk("halt_valid", instr_valid, 0);
    tick();
    chk("done_hold", done, 1);
    req = 0;
    tick();
    chk("done_fall", done, 0);
    $display("txn linear run complete pc=0x%0h", prog_ctr);

    // Relative jumps and wrap
    req = 1;
    tick();
    req = 0;
    jump_en = 1; jump_mode = 2'b00; branch_off = 12'd10;
    tick();
    chk("rel_fwd", prog_ctr, 12'h00A);
    branch_off = 12'hFFD;
    tick();
    chk("rel_back", prog_ctr, 12'h007);
    clr_ctl();
    lut_we = 1; lut_waddr = 4'd1; lut_wdata = 12'hFFF;
    tick();
    chk("req_low_run", prog_ctr, 12'h008);
    clr_ctl();
    jump_en = 1; jump_mode = 2'b01; lut_idx = 4'd1;
    tick();
    chk("abs_fff", prog_ctr, 12'hFFF);
    clr_ctl();
    tick();
    chk("wrap", prog_ctr, 12'h000);
    $display("txn relative/wrap pc=0x%0h", prog_ctr);

    // Call/return including nested
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 12'h120;
    tick();
    lut_waddr = 4'd2; lut_wdata = 12'h040;
    tick();
    clr_ctl();
    jump_en = 1; jump_mode = 2'b01; lut_idx = 4'd2;
    tick();
    chk("abs_040", prog_ctr, 12'h040);
    jump_mode = 2'b10; lut_idx = 4'd3;
    tick();
    chk("call_pc", prog_ctr, 12'h120);
    chk("call_sp", sp, 1);
    clr_ctl();
    tick();
    jump_en = 1; jump_mode = 2'b10; lut_idx = 4'd2;
    tick();
    chk("call2_pc", prog_ctr, 12'h040);
    chk("call2_sp", sp, 2);
    jump_mode = 2'b11;
    tick();
    chk("ret2_pc", prog_ctr, 12'h122);
    chk("ret2_sp", sp, 1);
    tick();
    chk("ret1_pc", prog_ctr, 12'h041);
    chk("ret1_sp", sp, 0);
    clr_ctl();
    halt = 1;
    tick();
    halt = 0;
    tick();
    $display("txn call/return pc=0x%0h sp=%0d", prog_ctr, sp);

    // Overflow on fifth nested call
    req = 1;
    tick();
    jump_en = 1; jump_mode = 2'b10; lut_idx = 4'd3;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("nest_sp%0d", i), sp, i);
    end
    tick();
    chk("ovf_err", stack_err, 1);
    chk("ovf_done", done, 1);
    chk("ovf_sp", sp, 4);
    chk("ovf_pc", prog_ctr, 12'h120);
    clr_ctl();
    req = 0;
    tick();
    chk("err_hold_idle", stack_err, 1);
    $display("txn overflow err=%0d sp=%0d", stack_err, sp);

    // Underflow on fresh run
    req = 1;
    tick();
    chk("restart_err", stack_err, 0);
    chk("restart_sp", sp, 0);
    jump_en = 1; jump_mode = 2'b11;
    tick();
    chk("udf_err", stack_err, 1);
    chk("udf_done", done, 1);
    clr_ctl();
    req = 0;
    tick();
    $display("txn underflow err=%0d", stack_err);

    // halt beats jump; stall holds
    req = 1;
    tick();
    tick();
    halt = 1; jump_en = 1; branch_off = 12'd5;
    tick();
    chk("hj_pc", prog_ctr, 12'h001);
    chk("hj_done", done, 1);
    clr_ctl();
    req = 0;
    tick();
    req = 1;
    tick();
    stall = 1; halt = 1; jump_en = 1; branch_off = 12'd7;
    #1;
    chk("stall_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_pc%0d", i), prog_ctr, 12'h000);
    end
    clr_ctl();
    tick();
    chk("unstall_pc", prog_ctr, 12'h001);
    $display("txn stall/halt pc=0x%0h", prog_ctr);

    // Asynchronous reset mid-run at PC=0x033, sp=2
    lut_we = 1; lut_waddr = 4'd4; lut_wdata = 12'h031;
    tick();
    clr_ctl();
    jump_en = 1; jump_mode = 2'b10; lut_idx = 4'd3;
    tick();
    lut_idx = 4'd4;
    tick();
    clr_ctl();
    tick();
    tick();
    chk("pre_rst_pc", prog_ctr, 12'h033);
    chk("pre_rst_sp", sp, 2);
    #2;
    reset = 0;
    #1;
    chk("arst_pc", prog_ctr, 0);
    chk("arst_sp", sp, 0);
    chk("arst_done", done, 0);
    chk("arst_valid", instr_valid, 0);
    tick();
    reset = 1;
    $display("txn async reset pc=0x%0h", prog_ctr);

    // Same-cycle LUT write and call read old entry
    tick();
    chk("post_rst_pc", prog_ctr, 12'h000);
    tick();
    lut_we = 1; lut_waddr = 4'd5; lut_wdata = 12'h0AA;
    tick();
    lut_wdata = 12'h2AB;
    jump_en = 1; jump_mode = 2'b10; lut_idx = 4'd5;
    tick();
    chk("wr_call_old", prog_ctr, 12'h0AA);
    chk("wr_call_sp", sp, 1);
    clr_ctl();
    jump_en = 1; jump_mode = 2'b11;
    tick();
    chk("wr_ret", prog_ctr, 12'h003);
    jump_mode = 2'b01; lut_idx = 4'd5;
    tick();
    chk("wr_landed", prog_ctr, 12'h2AB);
    lut_idx = 4'd3;
    tick();
    chk("lut_cleared", prog_ctr, 12'h000);
    clr_ctl();
    halt = 1;
    tick();
    clr_ctl();
    req = 0;
    tick();
    $display("txn lut write/read pc=0x%0h", prog_ctr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
